hazard_detect_unit: RTL
=======================

# hazard_detect_unit

- Generates the `Check` bubble request that the decode-stage control squash mux consumes.
- Detects load-use and branch/jump-register operand hazards in ID and holds PC and IF/ID while bubbles are inserted.
- Flushes IF/ID on taken control transfers.
- Sits between the ID/EX and EX/MEM pipeline registers and the fetch/decode control.

## Interface
Parameters:
- `REG_W`, 5: register specifier width.
- `CNT_W`, 32: stall statistics counter width.

Ports:
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  reset; asynchronous, active-high.
- `IDRs`  in  REG_W  rs of the instruction in ID.
- `IDRt`  in  REG_W  rt of the instruction in ID.
- `IDUsesRt`  in  1  ID instruction reads rt (R-type, beq/bne, sw).
- `IDBranch`  in  1  ID instruction is a conditional branch (resolved in ID).
- `IDJr`  in  1  ID instruction is jr.
- `IDJump`  in  1  ID instruction is j/jal.
- `BranchTaken`  in  1  branch comparator result in ID.
- `EXMemRead`  in  1  instruction in EX is a load.
- `EXRegWrite`  in  1  instruction in EX writes a register.
- `EXWriteReg`  in  REG_W  destination of the EX instruction.
- `MEMMemRead`  in  1  instruction in MEM is a load.
- `MEMWriteReg`  in  REG_W  destination of the MEM instruction.
- `Check`  out  1  1 = zero the ID control word (insert bubble).
- `PCWrite`  out  1  1 = PC may update.
- `IFIDWrite`  out  1  1 = IF/ID may load.
- `IFIDFlush`  out  1  1 = IF/ID loads a NOP.
- `StallCount`  out  CNT_W  total bubble cycles since reset.

## Operation
- A register match requires destination != 0 and destination == IDRs, or destination == IDRt with IDUsesRt=1.
- `ctl` = IDBranch | IDJr.
- Stall need `n`, evaluated combinationally in state RUN:
  - n=2: ctl and EXMemRead and match on EXWriteReg.
  - n=1: EXMemRead and match on EXWriteReg (load-use), with ctl=0.
  - n=1: ctl and EXRegWrite and !EXMemRead and match on EXWriteReg.
  - n=1: ctl and MEMMemRead and match on MEMWriteReg.
  - n=0: otherwise.
- States:
  - RUN, n=0: Check=0, PCWrite=1, IFIDWrite=1. IFIDFlush=1 if IDJump, IDJr, or (IDBranch & BranchTaken). Next state RUN.
  - RUN, n=1: Check=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0. Next state RUN; hazards are re-evaluated on the next cycle.
  - RUN, n=2: same outputs as n=1. Next state HOLD.
  - HOLD: Check=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0, regardless of inputs. Next state RUN.
- Stall and flush in the same cycle: the stall wins and the flush is suppressed. The flush is issued on the first non-stalled cycle, once operands are valid.
- StallCount increments by 1 on every edge where Check=1. It saturates at all-ones and does not wrap.

## Timing
- Check, PCWrite, IFIDWrite and IFIDFlush are Mealy outputs: combinational from the state register and same-cycle inputs, zero latency.
- State and StallCount update on the rising edge of Clk.
- While Rst=1: state=RUN, StallCount=0, Check=1, PCWrite=0, IFIDWrite=0, IFIDFlush=0.
- First cycle after Rst deasserts: normal RUN evaluation.
- Rst asserted in HOLD: the block returns to RUN asynchronously; no residual bubble after release.
- Total bubbles per hazard:
  - Load followed by a dependent branch/jr: exactly 2.
  - Every other hazard case: exactly 1.
- No combinational path from Check back into the hazard inputs; the ID/EX inputs come from pipeline registers.

## Configuration
- `HAZARD_STATS_EN`:
  - Defined: the StallCount counter is built and behaves as above.
  - Undefined: no counter flops are built; StallCount is tied to 0.
  - Stall, flush and FSM behaviour are identical either way.

## Test plan
- Load-use: EX `lw` with EXWriteReg=8; ID `add` with IDRs=8.
  - Required: Check=1, PCWrite=0 for exactly 1 cycle, then 0/1.
  - StallCount goes 0→1.
- Load then dependent branch: EX `lw` with EXWriteReg=9; ID `beq` with IDRt=9, IDUsesRt=1.
  - Required: Check=1 for 2 consecutive cycles (RUN→HOLD→RUN).
  - StallCount goes 0→2.
- ALU result to branch: EX `add` with EXRegWrite=1, EXWriteReg=10; ID `bne` with IDRs=10.
  - Required: Check=1 for 1 cycle; IFIDFlush=0 during the stall.
  - Next cycle with BranchTaken=1: IFIDFlush=1, Check=0.
- $zero destination: EXMemRead=1, EXWriteReg=0, IDRs=0.
  - Required: Check=0, PCWrite=1 every cycle.
  - StallCount stays 0.
- Jump: IDJump=1 with no hazard.
  - Required: IFIDFlush=1 for 1 cycle, PCWrite=1, Check=0.
- Reset mid-HOLD: pulse Rst during HOLD.
  - Required: Check=1 and StallCount=0 while Rst=1.
  - After release with no hazard: Check=0 on the first cycle.

Source files
------------

// File: rtl/hazard_detect_unit.sv
// Pipeline hazard unit: load-use / control-operand stall FSM plus IF/ID flush control.
// Optional HAZARD_STATS_EN builds the saturating bubble counter; otherwise StallCount is 0.
module hazard_detect_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [REG_W-1:0] IDRs,
    input  logic [REG_W-1:0] IDRt,
    input  logic             IDUsesRt,
    input  logic             IDBranch,
    input  logic             IDJr,
    input  logic             IDJump,
    input  logic             BranchTaken,
    input  logic             EXMemRead,
    input  logic             EXRegWrite,
    input  logic [REG_W-1:0] EXWriteReg,
    input  logic             MEMMemRead,
    input  logic [REG_W-1:0] MEMWriteReg,
    output logic             Check,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

    state_e     state_q, state_d;
    logic       ex_match, mem_match, ctl;
    logic [1:0] need;

    always_comb begin
        ex_match  = (EXWriteReg != '0) &&
                    ((EXWriteReg == IDRs) || (IDUsesRt && (EXWriteReg == IDRt)));
        mem_match = (MEMWriteReg != '0) &&
                    ((MEMWriteReg == IDRs) || (IDUsesRt && (MEMWriteReg == IDRt)));
        ctl       = IDBranch | IDJr;

        // A load feeding a branch/jr needs two bubbles: data arrives only after MEM.
        if (ctl && EXMemRead && ex_match)
            need = 2'd2;
        else if (EXMemRead && ex_match)
            need = 2'd1;
        else if (ctl && EXRegWrite && ex_match)
            need = 2'd1;
        else if (ctl && MEMMemRead && mem_match)
            need = 2'd1;
        else
            need = 2'd0;
    end

    always_comb begin
        state_d   = RUN;
        Check     = 1'b0;
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        if (Rst) begin
            Check     = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (state_q == HOLD) begin
            Check     = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (need != 2'd0) begin
            // Stall wins over flush; the redirect is taken once operands are valid.
            Check     = 1'b1;
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            state_d   = (need == 2'd2) ? HOLD : RUN;
        end else begin
            IFIDFlush = IDJump | IDJr | (IDBranch & BranchTaken);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Check && (cnt_q != '1))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign StallCount = cnt_q;
`else
    assign StallCount = '0;
`endif

endmodule
